// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the IF/MEM byte-RAM arbiter
package mem_arbiter_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IF_RD  = 2'd1,
        ARB_MEM_RD = 2'd2,
        ARB_MEM_WR = 2'd3
    } arb_state_e;

    localparam logic STALL_STOP   = 1'b1;
    localparam logic STALL_NOSTOP = 1'b0;

    // Size code 2'b11 falls through to a word, as the pipeline never issues it.
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            MEM_SZ_B: return 3'd1;
            MEM_SZ_H: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IF/MEM requester and byte-RAM signals; MEM_MISALIGN_CHK_EN adds mem_misalign
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic              mem_signed;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              stall_if;
    logic              stall_mem;
`ifdef MEM_MISALIGN_CHK_EN
    logic              mem_misalign;
`endif

    modport slave (
        input  if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_signed,
               mem_addr, mem_wdata, ram_din,
        output if_rdata, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout,
               stall_if, stall_mem
`ifdef MEM_MISALIGN_CHK_EN
        , output mem_misalign
`endif
    );

    modport master (
        output if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_signed,
               mem_addr, mem_wdata, ram_din,
        input  if_rdata, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout,
               stall_if, stall_mem
`ifdef MEM_MISALIGN_CHK_EN
        , input mem_misalign
`endif
    );

endinterface

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - combinational sign/zero extension of assembled load data
module mem_load_ext
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    always_comb begin
        dout = din;
        case (size)
            MEM_SZ_B: dout = {{24{sign_ext & din[7]}}, din[7:0]};
            MEM_SZ_H: dout = {{16{sign_ext & din[15]}}, din[15:0]};
            default:  dout = din;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises IF fetches and MEM loads/stores onto one byte-wide RAM
// MEM_MISALIGN_CHK_EN: misaligned half/word MEM requests complete at once with mem_misalign.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int RAM_RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    generate
        if (RAM_RD_LAT != 1) begin : g_lat_chk
            $error("mem_arbiter supports RAM_RD_LAT=1 only");
        end
    endgenerate

    arb_state_e        state, state_nx;
    logic [2:0]        cnt, n_beats;
    logic [1:0]        size_q, lane;
    logic              signed_q;
    logic [31:8]       wdata_q;
    logic [31:0]       rbuf, asm_word, ext_word, if_rdata_q, mem_rdata_q;
    logic              if_done_q, mem_done_q, ram_wr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_dout_q;
    logic              mem_ok, if_ok, misalign, grant_mem, grant_if, rd_last, wr_last;

    // A port's own done cycle masks its still-held request.
    assign mem_ok = bus.mem_req & ~mem_done_q;
    assign if_ok  = bus.if_req & ~if_done_q & ~bus.if_flush;

`ifdef MEM_MISALIGN_CHK_EN
    logic mem_misalign_q;
    assign misalign = ((bus.mem_size == MEM_SZ_H) & bus.mem_addr[0])
                    | (bus.mem_size[1] & (bus.mem_addr[1:0] != 2'b00));
    assign bus.mem_misalign = mem_misalign_q;
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        rd_last   = 1'b0;
        wr_last   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (mem_ok) begin
                    grant_mem = 1'b1;
                    if (!misalign) state_nx = bus.mem_we ? ARB_MEM_WR : ARB_MEM_RD;
                end else if (if_ok) begin
                    grant_if = 1'b1;
                    state_nx = ARB_IF_RD;
                end
            end
            ARB_IF_RD: begin
                if (bus.if_flush) begin
                    state_nx = ARB_IDLE;
                end else if (cnt == n_beats) begin
                    rd_last  = 1'b1;
                    state_nx = ARB_IDLE;
                end
            end
            ARB_MEM_RD: begin
                if (cnt == n_beats) begin
                    rd_last  = 1'b1;
                    state_nx = ARB_IDLE;
                end
            end
            default: begin
                if (cnt == n_beats - 3'd1) begin
                    wr_last  = 1'b1;
                    state_nx = ARB_IDLE;
                end
            end
        endcase
    end

    // ram_din in this cycle belongs to the address issued one cycle earlier.
    always_comb begin
        lane     = cnt[1:0] - 2'd1;
        asm_word = rbuf;
        if (cnt != 3'd0) asm_word[{lane, 3'b000} +: 8] = bus.ram_din;
    end

    mem_load_ext u_load_ext (
        .size     (size_q),
        .sign_ext (signed_q),
        .din      (asm_word),
        .dout     (ext_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            cnt         <= 3'd0;
            n_beats     <= 3'd0;
            size_q      <= MEM_SZ_B;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            rbuf        <= '0;
            if_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
`ifdef MEM_MISALIGN_CHK_EN
            mem_misalign_q <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
            mem_misalign_q <= 1'b0;
`endif
            if (grant_mem && misalign) begin
                mem_done_q  <= 1'b1;
                mem_rdata_q <= '0;
`ifdef MEM_MISALIGN_CHK_EN
                mem_misalign_q <= 1'b1;
`endif
            end else if (grant_mem) begin
                cnt        <= 3'd0;
                n_beats    <= beat_count(bus.mem_size);
                size_q     <= bus.mem_size;
                signed_q   <= bus.mem_signed;
                wdata_q    <= bus.mem_wdata[31:8];
                rbuf       <= '0;
                ram_addr_q <= bus.mem_addr;
                ram_wr_q   <= bus.mem_we;
                if (bus.mem_we) ram_dout_q <= bus.mem_wdata[7:0];
            end else if (grant_if) begin
                cnt        <= 3'd0;
                n_beats    <= 3'd4;
                rbuf       <= '0;
                ram_addr_q <= bus.if_addr;
                ram_wr_q   <= 1'b0;
            end else if (state == ARB_MEM_WR) begin
                if (wr_last) begin
                    cnt        <= 3'd0;
                    ram_wr_q   <= 1'b0;
                    mem_done_q <= 1'b1;
                end else begin
                    cnt        <= cnt + 3'd1;
                    ram_addr_q <= ram_addr_q + ADDR_W'(1);
                    ram_dout_q <= wdata_q[{cnt[1:0] + 2'd1, 3'b000} +: 8];
                end
            end else if (state != ARB_IDLE) begin
                if (state_nx == ARB_IDLE && !rd_last) begin
                    cnt <= 3'd0;
                end else begin
                    if (cnt != 3'd0) rbuf <= asm_word;
                    if (cnt < n_beats - 3'd1) ram_addr_q <= ram_addr_q + ADDR_W'(1);
                    if (rd_last) begin
                        cnt <= 3'd0;
                        if (state == ARB_IF_RD) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= asm_word;
                        end else begin
                            mem_done_q  <= 1'b1;
                            mem_rdata_q <= ext_word;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
            end
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.stall_if  = (bus.if_req && !if_done_q) ? STALL_STOP : STALL_NOSTOP;
    assign bus.stall_mem = (bus.mem_req && !mem_done_q) ? STALL_STOP : STALL_NOSTOP;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a byte RAM model
// MEM_MISALIGN_CHK_EN selects the misaligned-access expectations.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] ram [0:1023];

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .RAM_RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.ram_din <= ram[bus.ram_addr[9:0]];
        if (bus.ram_wr) ram[bus.ram_addr[9:0]] = bus.ram_dout;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the start of cycle 0; returns in the cycle after done with mem_req dropped.
    task automatic mem_xfer(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input string tag);
        int n, d;
        logic [31:0] ea;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        d = we ? n + 1 : n + 2;
        bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_size = sz;
        bus.mem_signed = sg; bus.mem_addr = addr; bus.mem_wdata = wd;
        #1;
        chk({tag, " stall_mem c0"}, bus.stall_mem, 1);
        for (int c = 1; c <= d; c++) begin
            tick();
            if (c <= n) begin
                ea = addr + 32'(c - 1);
                chk($sformatf("%s ram_addr c%0d", tag, c), bus.ram_addr, ea);
                chk($sformatf("%s ram_wr c%0d", tag, c), bus.ram_wr, we);
                if (we) chk($sformatf("%s ram_dout c%0d", tag, c), bus.ram_dout, wd[8*(c-1) +: 8]);
            end
            if (c == d - 1) chk($sformatf("%s mem_done c%0d", tag, c), bus.mem_done, 0);
            if (c == d) begin
                chk($sformatf("%s mem_done c%0d", tag, c), bus.mem_done, 1);
                chk($sformatf("%s stall_mem c%0d", tag, c), bus.stall_mem, 0);
                if (!we) chk($sformatf("%s mem_rdata", tag), bus.mem_rdata, exp_rd);
            end
        end
        tick();
        bus.mem_req = 1'b0;
    endtask

    // Byte load at 0x20 racing a fetch at 0x100; MEM wins, IF is granted in the mem_done cycle.
    task automatic race(input logic sg, input logic [31:0] exp_rd);
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'b00;
        bus.mem_signed = sg; bus.mem_addr = 32'h20;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        #1;
        chk("race stall_if c0", bus.stall_if, 1);
        chk("race stall_mem c0", bus.stall_mem, 1);
        tick();
        chk("race ram_addr c1", bus.ram_addr, 32'h20);
        tick();
        tick();
        chk("race mem_done c3", bus.mem_done, 1);
        chk("race mem_rdata", bus.mem_rdata, exp_rd);
        chk("race stall_if c3", bus.stall_if, 1);
        tick();
        bus.mem_req = 1'b0;
        #1;
        chk("race if ram_addr c4", bus.ram_addr, 32'h100);
        for (int c = 5; c <= 9; c++) begin
            tick();
            if (c == 8) chk("race if_done c8", bus.if_done, 0);
        end
        chk("race if_done c9", bus.if_done, 1);
        chk("race if_rdata", bus.if_rdata, 32'h00A00513);
        tick();
        bus.if_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'hA0; ram[10'h103] = 8'h00;
        ram[10'h020] = 8'h80; ram[10'h044] = 8'h77; ram[10'h3FF] = 8'h34; ram[10'h000] = 8'h92;
        ram[10'h200] = 8'h78; ram[10'h201] = 8'h56; ram[10'h202] = 8'h34; ram[10'h203] = 8'h12;
        for (int i = 10'h60; i < 10'h64; i++) ram[i] = 8'h11;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = 2'b00;
        bus.mem_signed = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;

        tick();
        tick();
        chk("rst if_rdata", bus.if_rdata, 0);
        chk("rst if_done", bus.if_done, 0);
        chk("rst mem_rdata", bus.mem_rdata, 0);
        chk("rst mem_done", bus.mem_done, 0);
        chk("rst ram_addr", bus.ram_addr, 0);
        chk("rst ram_wr", bus.ram_wr, 0);
        chk("rst ram_dout", bus.ram_dout, 0);
`ifdef MEM_MISALIGN_CHK_EN
        chk("rst mem_misalign", bus.mem_misalign, 0);
`endif
        rst = 1'b0;

        // Plain word fetch: beats in cycles 1-4, done in cycle 6.
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        #1;
        chk("fetch stall_if c0", bus.stall_if, 1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) begin
                chk($sformatf("fetch ram_addr c%0d", c), bus.ram_addr, 32'h100 + 32'(c - 1));
                chk($sformatf("fetch ram_wr c%0d", c), bus.ram_wr, 0);
            end
            if (c <= 5) begin
                chk($sformatf("fetch stall_if c%0d", c), bus.stall_if, 1);
                chk($sformatf("fetch if_done c%0d", c), bus.if_done, 0);
            end
        end
        chk("fetch if_done c6", bus.if_done, 1);
        chk("fetch if_rdata", bus.if_rdata, 32'h00A00513);
        chk("fetch stall_if c6", bus.stall_if, 0);
        tick();
        bus.if_req = 1'b0;
        tick();
        chk("fetch idle if_done", bus.if_done, 0);
        chk("fetch idle ram_addr hold", bus.ram_addr, 32'h103);

        race(1'b1, 32'hFFFFFF80);
        race(1'b0, 32'h00000080);

        mem_xfer(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, "st_w");
        mem_xfer(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, "ld_w");
        mem_xfer(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, "ld_sz3");
        mem_xfer(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 32'h000000DE, "ld_bu");
        mem_xfer(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'hFFFFDEAD, "ld_hs");

`ifdef MEM_MISALIGN_CHK_EN
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'b10;
        bus.mem_signed = 1'b0; bus.mem_addr = 32'h41;
        tick();
        chk("misal mem_done c1", bus.mem_done, 1);
        chk("misal flag c1", bus.mem_misalign, 1);
        chk("misal mem_rdata", bus.mem_rdata, 0);
        chk("misal ram_wr c1", bus.ram_wr, 0);
        chk("misal ram_addr c1", bus.ram_addr, 32'h43);
        tick();
        bus.mem_req = 1'b0;
        #1;
        chk("misal flag c2", bus.mem_misalign, 0);
        chk("misal ram_addr c2", bus.ram_addr, 32'h43);
`else
        mem_xfer(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h77DEADBE, "misal_w");
        mem_xfer(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0, 32'hFFFF9234, "wrap_h");
`endif

        // Flush in cycle 2 aborts the fetch; the redirected fetch is granted in cycle 3.
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        #1;
        chk("flush stall_if c0", bus.stall_if, 1);
        tick();
        chk("flush ram_addr c1", bus.ram_addr, 32'h300);
        tick();
        bus.if_flush = 1'b1;
        #1;
        chk("flush ram_addr c2", bus.ram_addr, 32'h301);
        tick();
        bus.if_flush = 1'b0; bus.if_addr = 32'h200;
        #1;
        chk("flush if_done c3", bus.if_done, 0);
        chk("flush ram_addr c3", bus.ram_addr, 32'h301);
        chk("flush if_rdata kept", bus.if_rdata, 32'h00A00513);
        chk("flush stall_if c3", bus.stall_if, 1);
        for (int c = 4; c <= 9; c++) begin
            tick();
            if (c <= 7) chk($sformatf("refetch ram_addr c%0d", c), bus.ram_addr, 32'h200 + 32'(c - 4));
            if (c <= 8) chk($sformatf("refetch if_done c%0d", c), bus.if_done, 0);
        end
        chk("refetch if_done c9", bus.if_done, 1);
        chk("refetch if_rdata", bus.if_rdata, 32'h12345678);
        tick();
        bus.if_req = 1'b0;

        // Reset in cycle 2 of a word store leaves bytes 0-1 written only.
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'b10;
        bus.mem_addr = 32'h60; bus.mem_wdata = 32'hCAFEF00D;
        tick();
        chk("rstst ram_dout c1", bus.ram_dout, 8'h0D);
        tick();
        rst = 1'b1;
        #1;
        chk("rstst ram_addr c2", bus.ram_addr, 32'h61);
        tick();
        rst = 1'b0; bus.mem_req = 1'b0;
        #1;
        chk("rstst ram_wr c3", bus.ram_wr, 0);
        chk("rstst ram_addr c3", bus.ram_addr, 0);
        chk("rstst ram_dout c3", bus.ram_dout, 0);
        chk("rstst mem_done c3", bus.mem_done, 0);
        chk("rstst if_rdata c3", bus.if_rdata, 0);
        tick();
        chk("rstst mem_done c4", bus.mem_done, 0);
        chk("rstst ram_wr c4", bus.ram_wr, 0);
        chk("rstst ram[60]", ram[10'h060], 8'h0D);
        chk("rstst ram[61]", ram[10'h061], 8'hF0);
        chk("rstst ram[62]", ram[10'h062], 8'h11);
        chk("rstst ram[63]", ram[10'h063], 8'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
